// File: rtl/sync_counter_pkg.sv
// Shared definitions for the synchronous up/down counter slice:
// direction encoding, default width and the binary-to-Gray helper.
package sync_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int unsigned CNT_WIDTH_DEF = 4;

  // Operates on a 32-bit container; callers cast to/from their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/sync_counter_gray.sv
// Gray-code shadow register for the counter. It registers the Gray
// encoding of the counter's next value, so it updates on the same edge
// as the binary count.
module sync_counter_gray
  import sync_counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bin_next,
  output logic [WIDTH-1:0] gray
);

  // Gray register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) gray <= '0;
    else     gray <= WIDTH'(bin2gray(32'(bin_next)));
  end

endmodule

// File: rtl/sync_updown_counter.sv
// Synchronous modulo-MODULUS up/down counter with parallel load (clamped),
// terminal-count flag for cascading and a sticky wrap indicator.
// Optional Gray-coded output port count_gray is present only when the
// macro SYNC_CNT_GRAY_EN is defined.
module sync_updown_counter
  import sync_counter_pkg::*;
#(
  parameter int WIDTH   = CNT_WIDTH_DEF,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
`ifdef SYNC_CNT_GRAY_EN
  ,
  output logic [WIDTH-1:0] count_gray
`endif
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_next;
  logic             wrapped_next;
  logic [WIDTH-1:0] load_clamped;

  // Next-state and terminal-count logic, priority rst > load > en > hold.
  always_comb begin
    count_next   = count;
    wrapped_next = wrapped;
    tc           = 1'b0;
    // One extra bit so MODULUS == 2**WIDTH compares correctly.
    load_clamped = ({1'b0, load_val} >= MOD_EXT) ? CNT_MAX : load_val;

    if (rst) begin
      count_next   = '0;
      wrapped_next = 1'b0;
    end else if (load) begin
      count_next   = load_clamped;
      wrapped_next = 1'b0;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        tc         = (count == CNT_MAX);
        count_next = tc ? '0 : count + 1'b1;
      end else begin
        tc         = (count == '0);
        count_next = tc ? CNT_MAX : count - 1'b1;
      end
      if (tc) wrapped_next = 1'b1;
    end
  end

  // State register for count and the sticky wrap flag.
  always_ff @(posedge clk) begin
    count   <= count_next;
    wrapped <= wrapped_next;
  end

`ifdef SYNC_CNT_GRAY_EN
  sync_counter_gray #(
    .WIDTH(WIDTH)
  ) u_gray (
    .clk      (clk),
    .rst      (rst),
    .bin_next (count_next),
    .gray     (count_gray)
  );
`endif

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed testbench for sync_updown_counter. Two instances share the
// stimulus: one with default parameters (modulus 16) and one with
// modulus 10. Expected values are hand-computed constants.
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] count16, count10;
  logic       tc16, tc10, wrapped16, wrapped10;
`ifdef SYNC_CNT_GRAY_EN
  logic [3:0] gray16, gray10;
`endif

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  sync_updown_counter dut16 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count    (count16),
    .tc       (tc16),
    .wrapped  (wrapped16)
`ifdef SYNC_CNT_GRAY_EN
    ,
    .count_gray (gray16)
`endif
  );

  sync_updown_counter #(
    .WIDTH   (4),
    .MODULUS (10)
  ) dut10 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count    (count10),
    .tc       (tc10),
    .wrapped  (wrapped10)
`ifdef SYNC_CNT_GRAY_EN
    ,
    .count_gray (gray10)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  // Advance one active edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset for two cycles with en and load both requesting.
    rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd5; up_dn = 1'b1;
    #1;
    check("rst_tc_pre", {31'd0, tc16}, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_count16", {28'd0, count16}, 0);
      check("rst_count10", {28'd0, count10}, 0);
      check("rst_wrapped16", {31'd0, wrapped16}, 0);
      check("rst_tc16", {31'd0, tc16}, 0);
      check("rst_tc10", {31'd0, tc10}, 0);
`ifdef SYNC_CNT_GRAY_EN
      check("rst_gray16", {28'd0, gray16}, 0);
`endif
    end

    // Count up 16 edges from 0: 1..15 then 0, tc high at 15.
    rst = 1'b0; load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      #1;
      check("up_tc16", {31'd0, tc16}, (i == 16) ? 1 : 0);
      check("up_wrapped16_pre", {31'd0, wrapped16}, 0);
      step();
      check("up_count16", {28'd0, count16}, i % 16);
    end
    check("up_wrapped16", {31'd0, wrapped16}, 1);
    check("up_count10", {28'd0, count10}, 6);
    check("up_wrapped10", {31'd0, wrapped10}, 1);

    // Load 0 clears wrapped; then count down from 0.
    load = 1'b1; load_val = 4'd0; en = 1'b0;
    step();
    check("ld0_count10", {28'd0, count10}, 0);
    check("ld0_wrapped10", {31'd0, wrapped10}, 0);
    check("ld0_wrapped16", {31'd0, wrapped16}, 0);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    #1;
    check("dn_tc10_at0", {31'd0, tc10}, 1);
    check("dn_tc16_at0", {31'd0, tc16}, 1);
    step();
    check("dn_count10_9", {28'd0, count10}, 9);
    check("dn_count16_15", {28'd0, count16}, 15);
    check("dn_wrapped10", {31'd0, wrapped10}, 1);
    check("dn_tc10_at9", {31'd0, tc10}, 0);
    step();
    check("dn_count10_8", {28'd0, count10}, 8);
    check("dn_count16_14", {28'd0, count16}, 14);

    // Load 12 with en high: clamp on modulus 10, en ignored, wrapped cleared.
    load = 1'b1; load_val = 4'd12; en = 1'b1; up_dn = 1'b1;
    #1;
    check("ld12_tc16", {31'd0, tc16}, 0);
    step();
    check("ld12_count10", {28'd0, count10}, 9);
    check("ld12_count16", {28'd0, count16}, 12);
    check("ld12_wrapped10", {31'd0, wrapped10}, 0);
    load = 1'b0; en = 1'b0;
    step();
    check("hold_count10", {28'd0, count10}, 9);
    check("hold_count16", {28'd0, count16}, 12);

    // Load 15: in range for modulus 16, clamps to 9 for modulus 10.
    load = 1'b1; load_val = 4'd15;
    step();
    check("ld15_count16", {28'd0, count16}, 15);
    check("ld15_count10", {28'd0, count10}, 9);

    // Up from 7, then direction flip takes effect immediately.
    load = 1'b1; load_val = 4'd7; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    step();
    check("dir_count16_8", {28'd0, count16}, 8);
    check("dir_count10_8", {28'd0, count10}, 8);
`ifdef SYNC_CNT_GRAY_EN
    check("dir_gray16_8", {28'd0, gray16}, 12);
`endif
    up_dn = 1'b0;
    step();
    check("dir_count16_7", {28'd0, count16}, 7);
    check("dir_count10_7", {28'd0, count10}, 7);
`ifdef SYNC_CNT_GRAY_EN
    check("dir_gray16_7", {28'd0, gray16}, 4);
`endif

    // Load 3, count to 5, then reset mid-count and resume.
    load = 1'b1; load_val = 4'd3; en = 1'b0;
    step();
`ifdef SYNC_CNT_GRAY_EN
    check("gray_3", {28'd0, gray16}, 2);
`endif
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    step();
    check("mid_count16_4", {28'd0, count16}, 4);
`ifdef SYNC_CNT_GRAY_EN
    check("gray_4", {28'd0, gray16}, 6);
`endif
    step();
    check("mid_count16_5", {28'd0, count16}, 5);
    rst = 1'b1;
    #1;
    check("mid_rst_tc16", {31'd0, tc16}, 0);
    step();
    check("mid_rst_count16", {28'd0, count16}, 0);
    check("mid_rst_count10", {28'd0, count10}, 0);
    check("mid_rst_wrapped16", {31'd0, wrapped16}, 0);
`ifdef SYNC_CNT_GRAY_EN
    check("mid_rst_gray16", {28'd0, gray16}, 0);
`endif
    rst = 1'b0;
    step();
    check("resume_count16", {28'd0, count16}, 1);
    check("resume_count10", {28'd0, count10}, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
